// File: rtl/sm4_axis_pkg.sv
// Shared AXI-Stream constants and payload type for the SM4 datapath.
//   AXIS_DW     : data width of one stream word (128)
//   PKT_CNT_W   : width of the delivered-packet counter (16)
//   axis_word_t : one stored stream word (tlast + tdata)
package sm4_axis_pkg;

    localparam int unsigned AXIS_DW   = 128;
    localparam int unsigned PKT_CNT_W = 16;

    // tlast is kept in the MSB so a stored word is {last, data}
    typedef struct packed {
        logic               last;
        logic [AXIS_DW-1:0] data;
    } axis_word_t;

    localparam int unsigned AXIS_WORD_W = $bits(axis_word_t);

endpackage

// File: rtl/sm4_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   wr_en, wr_data     : write request and word (ignored when full without a read)
//   rd_en              : consumer ready; a read happens on rd_valid & rd_en
//   rd_valid, rd_data  : registered head-of-queue word and its valid flag
//   count              : registered occupancy, 0..DEPTH
module sm4_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 129
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             full;
    logic             do_rd;
    logic             do_wr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] head_nxt;

    // Transfer qualification and the word that will sit at the head after this edge
    always_comb begin
        full      = (count == CW'(DEPTH));
        do_rd     = rd_valid & rd_en;
        do_wr     = wr_en & (~full | do_rd);
        count_nxt = count + CW'(do_wr) - CW'(do_rd);
        head_nxt  = rd_data;
        if (do_rd) begin
            // With a single stored word the next head can only be the incoming one;
            // otherwise the next slot was written on an earlier edge.
            if (count == CW'(1)) begin
                head_nxt = wr_data;
            end else begin
                head_nxt = mem[rd_ptr + PW'(1)];
            end
        end else if ((count == '0) && do_wr) begin
            head_nxt = wr_data;
        end
    end

    // Storage array; contents are never reset
    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered head word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            rd_data  <= head_nxt;
        end
    end

endmodule

// File: rtl/sm4_axis128_rx_buf.sv
// Receive-side elastic buffer between the SM4 core output stream (no
// back-pressure) and a downstream AXI-Stream consumer.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast   : words from the SM4 core (no tready)
//   m_axis_tdata/tvalid/tlast   : buffered stream to downstream
//   m_axis_tready               : downstream ready
//   almost_full                 : registered level >= AF_LEVEL, throttle hint
//   overflow                    : sticky, set when an incoming word was dropped
//   level                       : current occupancy
//   pkt_cnt                     : packets (tlast transfers) delivered, wraps
module sm4_axis128_rx_buf
    import sm4_axis_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DW-1:0]         s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic [AXIS_DW-1:0]         m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level,
    output logic [PKT_CNT_W-1:0]       pkt_cnt
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    axis_word_t    wr_word;
    axis_word_t    rd_word;
    logic          rd_fire;
    logic          full;
    logic          drop;
    logic          wr_fire;
    logic [LW-1:0] level_nxt;

    assign wr_word = '{last: s_axis_tlast, data: s_axis_tdata};

    sm4_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AXIS_WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (s_axis_tvalid),
        .wr_data  (wr_word),
        .rd_en    (m_axis_tready),
        .rd_valid (m_axis_tvalid),
        .rd_data  (rd_word),
        .count    (level)
    );

    assign m_axis_tdata = rd_word.data;
    assign m_axis_tlast = rd_word.last;

    // Mirror of the FIFO's accept decision, used for the status flags
    always_comb begin
        rd_fire   = m_axis_tvalid & m_axis_tready;
        full      = (level == LW'(DEPTH));
        drop      = s_axis_tvalid & full & ~rd_fire;
        wr_fire   = s_axis_tvalid & ~drop;
        level_nxt = level + LW'(wr_fire) - LW'(rd_fire);
    end

    // Status registers; a word arriving during reset is discarded silently
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            almost_full <= (level_nxt >= LW'(AF_LEVEL));
            if (drop) begin
                overflow <= 1'b1;
            end
            if (rd_fire && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sm4_axis128_rx_buf.sv
// Self-checking bench for sm4_axis128_rx_buf: a queue scoreboard is filled as
// words are driven and drained by a monitor on downstream transfers.
module tb_sm4_axis128_rx_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;

    typedef struct packed {
        logic         last;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         almost_full;
    logic         overflow;
    logic [4:0]   level;
    logic [15:0]  pkt_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sm4_axis128_rx_buf #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .level         (level),
        .pkt_cnt       (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every downstream transfer must match the oldest pushed word
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", 160'(m_axis_tdata), 160'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("m_tdata", 160'(m_axis_tdata), 160'(e.data));
                chk("m_tlast", 160'(m_axis_tlast), 160'(e.last));
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one s_axis word for one cycle; push it when the caller expects acceptance
    task automatic send(input logic [127:0] d, input logic l, input bit accept);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        if (accept) sb.push_back('{last: l, data: d});
        @(posedge clk) #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && level == 0) break;
            @(posedge clk) #1;
        end
        chk(tag, 160'(sb.size() == 0 && level == 0), 160'(1));
    endtask

    initial begin
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_tvalid", 160'(m_axis_tvalid), 160'(0));
        chk("rst_tdata",  160'(m_axis_tdata),  160'(0));
        chk("rst_tlast",  160'(m_axis_tlast),  160'(0));
        chk("rst_level",  160'(level),         160'(0));
        chk("rst_af",     160'(almost_full),   160'(0));
        chk("rst_ovf",    160'(overflow),      160'(0));
        chk("rst_pkt",    160'(pkt_cnt),       160'(0));

        // Four-word packet streaming through with tready high; no same-cycle bypass
        m_axis_tready = 1'b1;
        s_axis_tdata  = 128'hA0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        sb.push_back('{last: 1'b0, data: 128'hA0});
        @(negedge clk);
        chk("no_bypass_tvalid", 160'(m_axis_tvalid), 160'(0));
        @(posedge clk) #1;
        chk("fwft_tvalid", 160'(m_axis_tvalid), 160'(1));
        chk("fwft_tdata",  160'(m_axis_tdata),  160'(128'hA0));
        for (int i = 1; i < 4; i++) send(128'hA0 + 128'(i), (i == 3), 1'b1);
        @(posedge clk) #1;
        chk("pkt4_level", 160'(level),   160'(0));
        chk("pkt4_pkt",   160'(pkt_cnt), 160'(1));
        chk("pkt4_sb",    160'(sb.size()), 160'(0));

        // Fill to DEPTH with no reads, then overflow one word
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(128'hB000 + 128'(i), (i == 15), 1'b1);
            chk("fill_level", 160'(level),       160'(i + 1));
            chk("fill_af",    160'(almost_full), 160'((i + 1) >= AF));
            chk("fill_ovf",   160'(overflow),    160'(0));
        end
        send(128'hDEAD, 1'b1, 1'b0);
        chk("ovf_set",   160'(overflow), 160'(1));
        chk("ovf_level", 160'(level),    160'(16));
        chk("ovf_head",  160'(m_axis_tdata), 160'(128'hB000));
        drain("ovf_drain");
        chk("ovf_sticky", 160'(overflow), 160'(1));
        chk("ovf_pkt",    160'(pkt_cnt),  160'(1));

        // Full with simultaneous write and read: word accepted, level unchanged
        do_reset();
        for (int i = 0; i < 16; i++) send(128'hC000 + 128'(i), 1'b0, 1'b1);
        m_axis_tready = 1'b1;
        send(128'hC0FF, 1'b1, 1'b1);
        chk("full_rw_ovf",   160'(overflow), 160'(0));
        chk("full_rw_level", 160'(level),    160'(16));
        drain("full_rw_drain");
        chk("full_rw_ovf2", 160'(overflow), 160'(0));

        // Random back-pressure over 100 packets, feeder throttled by almost_full
        do_reset();
        for (int p = 0; p < 100; p++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int w = 0; w < n; w++) begin
                int guard;
                guard = 0;
                m_axis_tready = $urandom_range(0, 1);
                while ((almost_full || $urandom_range(0, 3) == 0) && guard < 200) begin
                    @(posedge clk) #1;
                    m_axis_tready = $urandom_range(0, 1);
                    guard++;
                end
                send(rnd128(), (w == n - 1), 1'b1);
            end
        end
        drain("rand_drain");
        chk("rand_pkt", 160'(pkt_cnt),  160'(100));
        chk("rand_ovf", 160'(overflow), 160'(0));

        // Reset in the middle of a packet, with a word arriving during reset
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(128'hD000 + 128'(i), 1'b0, 1'b1);
        rst           = 1'b1;
        s_axis_tdata  = 128'hD003;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk) #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        sb.delete();
        chk("mid_rst_tvalid", 160'(m_axis_tvalid), 160'(0));
        chk("mid_rst_level",  160'(level),         160'(0));
        chk("mid_rst_ovf",    160'(overflow),      160'(0));
        chk("mid_rst_pkt",    160'(pkt_cnt),       160'(0));
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) send(128'hE000 + 128'(i), (i == 4), 1'b1);
        drain("post_rst_drain");
        chk("post_rst_pkt", 160'(pkt_cnt),  160'(1));
        chk("post_rst_ovf", 160'(overflow), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm4_axis128_rx_buf.md
SM4_AXIS128_RX_BUF -- requirements
Module: sm4_axis128_rx_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16; FIFO depth in 128-bit words (power of two, 4..256).
REQ-002 SHALL have parameter AF_LEVEL, default 12; almost_full threshold in words.
REQ-003 SHALL have port clk  input  1  single clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port s_axis_tdata  input  128  ciphertext/plaintext word from the SM4 core m_axis.
REQ-006 SHALL have port s_axis_tvalid  input  1  word valid; no tready exists on this side.
REQ-007 SHALL have port s_axis_tlast  input  1  last word of packet.
REQ-008 SHALL have port m_axis_tdata  output  128  buffered word to downstream.
REQ-009 SHALL have port m_axis_tvalid  output  1  buffered word valid.
REQ-010 SHALL have port m_axis_tlast  output  1  buffered tlast.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have port almost_full  output  1  throttle hint to the SM4 feeder (level >= AF_LEVEL).
REQ-013 SHALL have port overflow  output  1  sticky; a word was dropped.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port pkt_cnt  output  16  completed packets delivered downstream.

Function
REQ-016 SHALL store each s_axis word with tvalid=1 together with its tlast, in arrival order.
REQ-017 SHALL be first-word-fall-through: a word written at edge N drives m_axis_tvalid=1 and its tdata/tlast after edge N, i.e. visible in cycle N+1.
REQ-018 SHALL treat a downstream transfer as m_axis_tvalid & m_axis_tready at a rising edge; tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-019 SHALL deassert m_axis_tvalid when level=0; m_axis_tdata SHALL then be don't-care.
REQ-020 SHALL update level by +1 on write-only, -1 on read-only, and leave it unchanged on simultaneous write and read.
REQ-021 At level=DEPTH with tvalid=1 and a downstream transfer in the same cycle, the incoming word SHALL be accepted (no drop).
REQ-022 At level=DEPTH with tvalid=1 and no downstream transfer, the incoming word SHALL be discarded, overflow SHALL set at that edge and stay at 1 until reset, and FIFO contents SHALL be unaffected.
REQ-023 At level=0 with tvalid=1 and tready=1, the word SHALL NOT bypass; it appears on m_axis the next cycle.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without disturbance.
REQ-025 almost_full SHALL be registered and reflect level >= AF_LEVEL after each edge.
REQ-026 pkt_cnt SHALL increment on each downstream transfer with m_axis_tlast=1 and wrap modulo 2^16.

Reset
REQ-027 While rst=1 at an edge: pointers and level reset to 0; m_axis_tvalid, m_axis_tlast, almost_full, overflow and pkt_cnt reset to 0; m_axis_tdata resets to 0.
REQ-028 Reset mid-packet SHALL flush all stored words; s_axis words arriving in a cycle with rst=1 SHALL be dropped without setting overflow.
REQ-029 Storage RAM contents SHALL NOT require reset.

Structure
REQ-030 A shared package sm4_axis_pkg SHALL hold the AXIS data width constant (128) and the pkt_cnt width (16).
REQ-031 Storage SHALL be one sub-module, sm4_sync_fifo (synchronous, width 129 = data + tlast, FWFT); the top adds overflow, almost_full and pkt_cnt logic.

Verification
REQ-032 Four words A0..A3 (A3 tlast), tready=1 -> m_axis emits A0..A3 one cycle after each input, tlast only on A3, pkt_cnt=1, level back to 0.
REQ-033 Write 16 words with tready=0 -> level=16, almost_full=1 from level 12; a 17th word -> overflow=1, then draining yields exactly the first 16 words.
REQ-034 At level=16 drive tvalid=1 and tready=1 in the same cycle -> no overflow, level stays 16, output order preserved.
REQ-035 Random tready (50%) over 100 packets of 1..8 words, fill kept below 16 -> data and tlast match input sequence, pkt_cnt=100, overflow=0; pointers wrap many times.
REQ-036 Reset asserted after 3 words of a 5-word packet -> next cycle m_axis_tvalid=0, level=0, overflow=0, pkt_cnt=0; a new packet afterwards passes intact.
